// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction-memory address and
// captures fetched words into the IF/ID register with stall, redirect/flush and HALT handling.
module if_stage #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [4:0]        HALT_OP  = 5'b00001,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_data,
  output logic [DATA_W-1:0] id_ir,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_valid,
  output logic              running,
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   pc_r, pc_nxt_s;
  logic [DATA_W-1:0]   ir_r, ir_nxt_s;
  logic [ADDR_W-1:0]   idpc_r, idpc_nxt_s;
  logic                valid_r, valid_nxt_s;
  logic                is_halt_s;

  assign is_halt_s = (im_data[DATA_W-1 -: 5] == HALT_OP);

  // State and IF/ID register update; reset wins over everything
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
      ir_r    <= NOP_WORD;
      idpc_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      ir_r    <= ir_nxt_s;
      idpc_r  <= idpc_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Next-state and next-datapath selection: redirect > stall > normal fetch
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ir_nxt_s    = ir_r;
    idpc_nxt_s  = idpc_r;
    valid_nxt_s = valid_r;
    case (state_r)
      ST_IDLE: begin
        ir_nxt_s    = NOP_WORD;
        valid_nxt_s = 1'b0;
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          pc_nxt_s    = redirect_pc;
          ir_nxt_s    = NOP_WORD;
          valid_nxt_s = 1'b0;
        end else if (stall) begin
          state_nxt_s = ST_RUN;
        end else begin
          ir_nxt_s    = im_data;
          idpc_nxt_s  = pc_r;
          valid_nxt_s = 1'b1;
          // HALT is delivered to decode but the PC stops on it
          if (is_halt_s) begin
            state_nxt_s = ST_HALTED;
          end else begin
            pc_nxt_s = pc_r + PC_ONE;
          end
        end
      end
      ST_HALTED: begin
        if (redirect) begin
          pc_nxt_s    = redirect_pc;
          ir_nxt_s    = NOP_WORD;
          valid_nxt_s = 1'b0;
          state_nxt_s = ST_RUN;
        end else if (stall) begin
          state_nxt_s = ST_HALTED;
        end else begin
          ir_nxt_s    = NOP_WORD;
          valid_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ir_nxt_s    = NOP_WORD;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Status decode of the state register
  always_comb begin
    running = 1'b0;
    halted  = 1'b0;
    case (state_r)
      ST_RUN:    running = 1'b1;
      ST_HALTED: halted  = 1'b1;
      default: begin
        running = 1'b0;
        halted  = 1'b0;
      end
    endcase
  end

  assign im_addr  = pc_r;
  assign id_ir    = ir_r;
  assign id_pc    = idpc_r;
  assign id_valid = valid_r;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios against fixed expectations,
// then randomized traffic against a rule-level fetch model.
module tb_if_stage;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  im_addr;
  logic [15:0] im_data;
  logic [15:0] id_ir;
  logic [7:0]  id_pc;
  logic        id_valid;
  logic        running;
  logic        halted;

  logic [15:0] mem [256];
  int n_checks = 0;
  int n_fails  = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode;
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [7:0]  m_idpc;
  logic        m_valid;

  if_stage dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .im_addr(im_addr),
    .im_data(im_data), .id_ir(id_ir), .id_pc(id_pc), .id_valid(id_valid),
    .running(running), .halted(halted)
  );

  assign im_data = mem[im_addr];

  always #5 clock = ~clock;

  // Apply one cycle of inputs, clock it, and advance the reference model by the fetch rules
  task automatic tick(input logic st, input logic sl, input logic rd,
                      input logic [7:0] rpc, input logic rs);
    logic [15:0] w;
    start = st; stall = sl; redirect = rd; redirect_pc = rpc; reset = rs;
    w = mem[m_pc];
    @(posedge clock);
    #1;
    if (!rs) begin
      m_mode = M_IDLE; m_pc = 8'h00; m_ir = 16'h0000; m_idpc = 8'h00; m_valid = 1'b0;
    end else if (m_mode == M_IDLE) begin
      m_ir = 16'h0000; m_valid = 1'b0;
      if (st) m_mode = M_RUN;
    end else if (rd) begin
      m_pc = rpc; m_ir = 16'h0000; m_valid = 1'b0; m_mode = M_RUN;
    end else if (!sl) begin
      if (m_mode == M_HALT) begin
        m_ir = 16'h0000; m_valid = 1'b0;
      end else begin
        m_ir = w; m_idpc = m_pc; m_valid = 1'b1;
        if (w[15:11] == 5'b00001) m_mode = M_HALT;
        else m_pc = 8'((int'(m_pc) + 1) % 256);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++; if (im_addr !== 8'h00) begin n_fails++; $display("FAIL reset_addr got %h want %h", im_addr, 8'h00); end
    n_checks++; if (id_ir !== 16'h0000) begin n_fails++; $display("FAIL reset_ir got %h want %h", id_ir, 16'h0000); end
    n_checks++; if (id_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got %b want 0", id_valid); end
    n_checks++; if ({running, halted} !== 2'b00) begin n_fails++; $display("FAIL reset_status got %b want 00", {running, halted}); end
  endtask

  task automatic test_fetch();
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++; if (running !== 1'b1 || id_valid !== 1'b0) begin n_fails++; $display("FAIL start_run got run=%b valid=%b want 1 0", running, id_valid); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      n_checks++; if (id_ir !== mem[k]) begin n_fails++; $display("FAIL fetch_ir%0d got %h want %h", k, id_ir, mem[k]); end
      n_checks++; if (id_pc !== 8'(k) || id_valid !== 1'b1) begin n_fails++; $display("FAIL fetch_pc%0d got %h/%b want %h/1", k, id_pc, id_valid, 8'(k)); end
    end
  endtask

  task automatic test_stall();
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      n_checks++; if (id_ir !== mem[4] || id_pc !== 8'h04 || im_addr !== 8'h05) begin
        n_fails++; $display("FAIL stall_hold got ir=%h pc=%h addr=%h want %h 04 05", id_ir, id_pc, im_addr, mem[4]); end
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++; if (id_ir !== mem[5] || id_pc !== 8'h05 || im_addr !== 8'h06) begin
      n_fails++; $display("FAIL stall_resume got ir=%h pc=%h addr=%h want %h 05 06", id_ir, id_pc, im_addr, mem[5]); end
  endtask

  task automatic test_redirect();
    int guard = 0;
    while (im_addr !== 8'h10 && guard < 64) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      guard++;
    end
    n_checks++; if (im_addr !== 8'h10) begin n_fails++; $display("FAIL reach_10 got %h want 10", im_addr); end
    tick(1'b0, 1'b1, 1'b1, 8'h4F, 1'b1);
    n_checks++; if (id_ir !== 16'h0000 || id_valid !== 1'b0 || im_addr !== 8'h4F) begin
      n_fails++; $display("FAIL redir_flush got ir=%h v=%b addr=%h want 0000 0 4f", id_ir, id_valid, im_addr); end
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++; if (id_ir !== mem[8'h4F] || id_pc !== 8'h4F) begin
      n_fails++; $display("FAIL redir_target got ir=%h pc=%h want %h 4f", id_ir, id_pc, mem[8'h4F]); end
  endtask

  task automatic test_halt();
    mem[8'h69] = {5'b00001, 11'($urandom)};
    tick(1'b0, 1'b0, 1'b1, 8'h69, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++; if (id_ir !== mem[8'h69] || id_pc !== 8'h69 || halted !== 1'b1 || im_addr !== 8'h69) begin
      n_fails++; $display("FAIL halt_capture got ir=%h pc=%h h=%b addr=%h want %h 69 1 69", id_ir, id_pc, halted, im_addr, mem[8'h69]); end
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    n_checks++; if (id_ir !== mem[8'h69] || id_valid !== 1'b1) begin
      n_fails++; $display("FAIL halt_stall got ir=%h v=%b want %h 1", id_ir, id_valid, mem[8'h69]); end
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++; if (id_ir !== 16'h0000 || id_valid !== 1'b0 || halted !== 1'b1 || im_addr !== 8'h69) begin
      n_fails++; $display("FAIL halt_bubble got ir=%h v=%b h=%b addr=%h want 0000 0 1 69", id_ir, id_valid, halted, im_addr); end
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++; if (halted !== 1'b1 || running !== 1'b0) begin n_fails++; $display("FAIL halt_start got h=%b r=%b want 1 0", halted, running); end
    tick(1'b0, 1'b0, 1'b1, 8'h20, 1'b1);
    n_checks++; if (running !== 1'b1 || id_ir !== 16'h0000 || im_addr !== 8'h20) begin
      n_fails++; $display("FAIL halt_exit got r=%b ir=%h addr=%h want 1 0000 20", running, id_ir, im_addr); end
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++; if (id_ir !== mem[8'h20] || id_pc !== 8'h20) begin
      n_fails++; $display("FAIL halt_resume got ir=%h pc=%h want %h 20", id_ir, id_pc, mem[8'h20]); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [3];
    exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00;
    tick(1'b0, 1'b0, 1'b1, 8'hFE, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      n_checks++; if (id_pc !== exp_pc[i] || id_ir !== mem[exp_pc[i]]) begin
        n_fails++; $display("FAIL wrap%0d got pc=%h ir=%h want %h %h", i, id_pc, id_ir, exp_pc[i], mem[exp_pc[i]]); end
    end
  endtask

  task automatic test_reset_mid_stall();
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++; if (im_addr !== 8'h03) begin n_fails++; $display("FAIL reach_03 got %h want 03", im_addr); end
    tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
    n_checks++; if (im_addr !== 8'h00 || running !== 1'b0 || halted !== 1'b0 || id_valid !== 1'b0 || id_ir !== 16'h0000 || id_pc !== 8'h00) begin
      n_fails++; $display("FAIL rst_mid got addr=%h r=%b h=%b v=%b ir=%h pc=%h want 00 0 0 0 0000 00",
                          im_addr, running, halted, id_valid, id_ir, id_pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) if ($urandom_range(0, 9) == 0) mem[i][15:11] = 5'b00001;
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           8'($urandom), $urandom_range(0, 99) != 0);
      n_checks++; if (im_addr !== m_pc || id_ir !== m_ir || id_pc !== m_idpc || id_valid !== m_valid ||
                      running !== (m_mode == M_RUN) || halted !== (m_mode == M_HALT)) begin
        n_fails++;
        $display("FAIL rand_c%0d got addr=%h ir=%h pc=%h v=%b r=%b h=%b want %h %h %h %b %b %b", c,
                 im_addr, id_ir, id_pc, id_valid, running, halted,
                 m_pc, m_ir, m_idpc, m_valid, m_mode == M_RUN, m_mode == M_HALT);
      end
    end
  endtask

  initial begin
    clock = 1'b0; reset = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    m_mode = M_IDLE; m_pc = 8'h00; m_ir = 16'h0000; m_idpc = 8'h00; m_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:11] == 5'b00001) mem[i][15] = 1'b1;
    end
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
